// File: rtl/rvfi_emitter.sv
// rvfi_emitter: buffers reference-model retirement records in a small FIFO
// and replays them as RVFI beats with a running 64-bit retirement order.
// A transferred trap beat parks the emitter in HALT until flush_i.
// Optional feature macro: RVFI_EMITTER_STALL_CNT_EN enables a saturating
// count of backpressure cycles on stall_cnt_o (tied to zero otherwise).
module rvfi_emitter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_valid_i,
    output logic            push_ready_o,
    input  logic [ILEN-1:0] push_insn_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic            push_trap_i,
    input  logic            flush_i,
    output logic            rvfi_valid_o,
    input  logic            rvfi_ready_i,
    output logic [63:0]     rvfi_order_o,
    output logic [ILEN-1:0] rvfi_insn_o,
    output logic [XLEN-1:0] rvfi_pc_rdata_o,
    output logic            rvfi_trap_o,
    output logic            halt_o,
    output logic [31:0]     stall_cnt_o
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    logic [ILEN-1:0]  insn_mem_r [DEPTH];
    logic [XLEN-1:0]  pc_mem_r   [DEPTH];
    logic [DEPTH-1:0] trap_mem_r;

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          live_r;
    logic [63:0]   order_r;
    state_t        state_r;
    state_t        state_nxt_s;

    logic empty_s;
    logic full_s;
    logic valid_s;
    logic push_s;
    logic xfer_s;

    // Occupancy flags, handshakes. Flush suppresses both push and transfer.
    assign empty_s      = (count_r == {(AW+1){1'b0}});
    assign full_s       = (count_r == DEPTH_CNT);
    assign push_ready_o = live_r & ~full_s;
    assign valid_s      = (state_r == ST_RUN) & ~empty_s;
    assign rvfi_valid_o = valid_s;
    assign push_s       = push_valid_i & push_ready_o & ~flush_i;
    assign xfer_s       = valid_s & rvfi_ready_i & ~flush_i;
    assign halt_o       = (state_r == ST_HALT);
    assign rvfi_order_o = order_r;

    // Holds push_ready_o low during reset and releases it on the first edge after.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle keep count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (xfer_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, xfer_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are masked at the outputs whenever empty.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            insn_mem_r[wr_ptr_r] <= push_insn_i;
            pc_mem_r[wr_ptr_r]   <= push_pc_i;
            trap_mem_r[wr_ptr_r] <= push_trap_i;
        end
    end

    // Head record drives the RVFI data outputs, zeroed when the FIFO is empty.
    always_comb begin
        rvfi_insn_o     = {ILEN{1'b0}};
        rvfi_pc_rdata_o = {XLEN{1'b0}};
        rvfi_trap_o     = 1'b0;
        if (empty_s) begin
            rvfi_insn_o     = {ILEN{1'b0}};
            rvfi_pc_rdata_o = {XLEN{1'b0}};
            rvfi_trap_o     = 1'b0;
        end else begin
            rvfi_insn_o     = insn_mem_r[rd_ptr_r];
            rvfi_pc_rdata_o = pc_mem_r[rd_ptr_r];
            rvfi_trap_o     = trap_mem_r[rd_ptr_r];
        end
    end

    // Retirement order advances once per transfer and wraps naturally at 2^64.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            order_r <= 64'd0;
        end else if (xfer_s) begin
            order_r <= order_r + 64'd1;
        end else begin
            order_r <= order_r;
        end
    end

    // Emitter state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: a transferred trap beat halts; flush always returns to RUN.
    always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (xfer_s && rvfi_trap_o) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALT: state_nxt_s = ST_HALT;
                default: state_nxt_s = ST_RUN;
            endcase
        end
    end

`ifdef RVFI_EMITTER_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles a valid beat waits on the consumer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_r <= 32'd0;
        end else if (valid_s && !rvfi_ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_rvfi_emitter.sv
// Self-checking bench for rvfi_emitter: a per-cycle vector table for fill,
// drain, concurrent push/pop and flush, plus hand sequences for trap/halt,
// reset mid-operation and the backpressure counter. A scoreboard queue holds
// every accepted record and is compared against each RVFI transfer.
module tb_rvfi_emitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_insn;
    logic [31:0] push_pc;
    logic        push_trap;
    logic        flush;
    logic        rvfi_valid;
    logic        rvfi_ready;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic [31:0] rvfi_pc;
    logic        rvfi_trap;
    logic        halt;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

`ifdef RVFI_EMITTER_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd7;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        trap;
    } rec_t;

    typedef struct packed {
        logic        pv;
        logic        trap;
        logic        rr;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] insn;
        logic        e_valid;
        logic        e_pready;
        logic        e_halt;
    } vec_t;

    rec_t        sb[$];
    logic [63:0] exp_order;
    vec_t        tbl[15];

    rvfi_emitter #(.DEPTH(4), .XLEN(32), .ILEN(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .push_valid_i    (push_valid),
        .push_ready_o    (push_ready),
        .push_insn_i     (push_insn),
        .push_pc_i       (push_pc),
        .push_trap_i     (push_trap),
        .flush_i         (flush),
        .rvfi_valid_o    (rvfi_valid),
        .rvfi_ready_i    (rvfi_ready),
        .rvfi_order_o    (rvfi_order),
        .rvfi_insn_o     (rvfi_insn),
        .rvfi_pc_rdata_o (rvfi_pc),
        .rvfi_trap_o     (rvfi_trap),
        .halt_o          (halt),
        .stall_cnt_o     (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic trap, input logic rr, input logic fl,
                         input logic [31:0] pc, input logic [31:0] insn);
        push_valid = pv;
        push_trap  = trap;
        rvfi_ready = rr;
        flush      = fl;
        push_pc    = pc;
        push_insn  = insn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic pv, input logic trap, input logic rr, input logic fl,
                                input logic [31:0] pc, input logic [31:0] insn,
                                input logic ev, input logic epr, input logic eh);
        vec_t v;
        v.pv = pv; v.trap = trap; v.rr = rr; v.fl = fl;
        v.pc = pc; v.insn = insn;
        v.e_valid = ev; v.e_pready = epr; v.e_halt = eh;
        return v;
    endfunction

    // Scoreboard: inputs are stable at the falling edge, so decide there what
    // the next rising edge will push and transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (rvfi_valid && rvfi_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'd1, 64'd0);
                    end else begin
                        rec_t r;
                        r = sb.pop_front();
                        chk("beat_order", rvfi_order, exp_order);
                        chk("beat_pc", {32'd0, rvfi_pc}, {32'd0, r.pc});
                        chk("beat_insn", {32'd0, rvfi_insn}, {32'd0, r.insn});
                        chk("beat_trap", {63'd0, rvfi_trap}, {63'd0, r.trap});
                        exp_order = exp_order + 64'd1;
                    end
                end
                if (push_valid && push_ready) begin
                    rec_t n;
                    n.insn = push_insn;
                    n.pc   = push_pc;
                    n.trap = push_trap;
                    sb.push_back(n);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_order = 64'd0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        //          pv    trap  rr    fl    pc             insn            v     pr    halt
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0013, 1'b1, 1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0010_0093, 1'b1, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0020_0113, 1'b1, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0030_0193, 1'b1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0040_0213, 1'b1, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0040_0213, 1'b1, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'h0050_0293, 1'b1, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0700, 32'h0060_0313, 1'b1, 1'b1, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0800, 32'h0070_0393, 1'b1, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0900, 32'h0080_0413, 1'b0, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

        // Reset values and the first-edge release of push_ready.
        #1;
        chk("rst_push_ready", {63'd0, push_ready}, 64'd0);
        chk("rst_valid", {63'd0, rvfi_valid}, 64'd0);
        chk("rst_order", rvfi_order, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_push_ready_pre", {63'd0, push_ready}, 64'd0);
        step();
        chk("rel_push_ready_post", {63'd0, push_ready}, 64'd1);

        // Fill, full backpressure, drain, concurrent push/pop, flush vs push.
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].pv, tbl[i].trap, tbl[i].rr, tbl[i].fl, tbl[i].pc, tbl[i].insn);
            step();
            chk($sformatf("tbl%0d_valid", i), {63'd0, rvfi_valid}, {63'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_push_ready", i), {63'd0, push_ready}, {63'd0, tbl[i].e_pready});
            chk($sformatf("tbl%0d_halt", i), {63'd0, halt}, {63'd0, tbl[i].e_halt});
        end

        // Trap beat halts the emitter; pushes still accepted until full.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0A00, 32'h0000_0073);
        step();
        chk("trap_head_valid", {63'd0, rvfi_valid}, 64'd1);
        chk("trap_head_flag", {63'd0, rvfi_trap}, 64'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0B00, 32'h0000_0013);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        chk("halt_set", {63'd0, halt}, 64'd1);
        chk("halt_valid", {63'd0, rvfi_valid}, 64'd0);
        step();
        chk("halt_hold", {63'd0, halt}, 64'd1);
        chk("halt_push_ready", {63'd0, push_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0C00 + 32'(k * 256), 32'h0000_0013);
            step();
        end
        chk("halt_full_push_ready", {63'd0, push_ready}, 64'd0);
        chk("halt_full_valid", {63'd0, rvfi_valid}, 64'd0);

        // Flush empties the FIFO, releases halt, keeps the order counter.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        step();
        chk("flush_halt", {63'd0, halt}, 64'd0);
        chk("flush_valid", {63'd0, rvfi_valid}, 64'd0);
        chk("flush_push_ready", {63'd0, push_ready}, 64'd1);
        chk("flush_order", rvfi_order, 64'd8);

        // Flush beats a same-cycle transfer and push.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0F00, 32'h0000_0013);
        step();
        chk("pre_flush_valid", {63'd0, rvfi_valid}, 64'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0013);
        step();
        chk("flush_xfer_valid", {63'd0, rvfi_valid}, 64'd0);
        chk("flush_xfer_order", rvfi_order, 64'd8);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1100, 32'h0000_0113);
        step();
        chk("post_flush_pc", {32'd0, rvfi_pc}, 64'h1100);
        chk("post_flush_order", rvfi_order, 64'd8);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        chk("post_flush_drained", {63'd0, rvfi_valid}, 64'd0);

        // Reset with three queued records.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010 + 32'(k * 16), 32'h0000_0033);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_order = 64'd0;
        chk("mid_rst_push_ready", {63'd0, push_ready}, 64'd0);
        chk("mid_rst_valid", {63'd0, rvfi_valid}, 64'd0);
        chk("mid_rst_halt", {63'd0, halt}, 64'd0);
        chk("mid_rst_insn", {32'd0, rvfi_insn}, 64'd0);
        chk("mid_rst_pc", {32'd0, rvfi_pc}, 64'd0);
        chk("mid_rst_trap", {63'd0, rvfi_trap}, 64'd0);
        chk("mid_rst_order", rvfi_order, 64'd0);
        chk("mid_rst_stall", {32'd0, stall_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("mid_rst_release_ready", {63'd0, push_ready}, 64'd1);

        // Single record with the consumer ready: one beat, order 0.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0013);
        step();
        chk("single_valid", {63'd0, rvfi_valid}, 64'd1);
        chk("single_order", rvfi_order, 64'd0);
        chk("single_pc", {32'd0, rvfi_pc}, 64'h8000_0000);
        chk("single_insn", {32'd0, rvfi_insn}, 64'h13);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        chk("single_done", {63'd0, rvfi_valid}, 64'd0);
        chk("single_order_next", rvfi_order, 64'd1);

        // Seven cycles of backpressure on a valid beat.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0093);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (7) step();
        chk("stall_valid_held", {63'd0, rvfi_valid}, 64'd1);
        chk("stall_pc_held", {32'd0, rvfi_pc}, 64'h44);
        chk("stall_count", {32'd0, stall_cnt}, {32'd0, EXP_STALL});
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        repeat (2) step();
        chk("stall_count_kept", {32'd0, stall_cnt}, {32'd0, EXP_STALL});
        chk("final_empty", {63'd0, rvfi_valid}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("final_order", exp_order, 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvfi_emitter.md
RVFI_EMITTER -- requirements
Module: rvfi_emitter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, PC width.
REQ-003 SHALL have parameter ILEN, default 32, instruction width.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port push_valid_i  input  1  reference-model retirement record offered.
REQ-007 SHALL have port push_ready_o  output  1  record accepted this cycle when high with push_valid_i.
REQ-008 SHALL have port push_insn_i  input  ILEN  retired instruction word.
REQ-009 SHALL have port push_pc_i  input  XLEN  retired instruction PC.
REQ-010 SHALL have port push_trap_i  input  1  record is a trap.
REQ-011 SHALL have port flush_i  input  1  synchronous FIFO clear and halt release.
REQ-012 SHALL have port rvfi_valid_o  output  1  RVFI beat valid.
REQ-013 SHALL have port rvfi_ready_i  input  1  consumer ready; transfer = rvfi_valid_o & rvfi_ready_i.
REQ-014 SHALL have port rvfi_order_o  output  64  retirement index of current beat.
REQ-015 SHALL have port rvfi_insn_o  output  ILEN  head record instruction.
REQ-016 SHALL have port rvfi_pc_rdata_o  output  XLEN  head record PC.
REQ-017 SHALL have port rvfi_trap_o  output  1  head record trap flag.
REQ-018 SHALL have port halt_o  output  1  emitter halted after trap beat.
REQ-019 SHALL have port stall_cnt_o  output  32  backpressure cycle count.

Function
REQ-020 SHALL buffer records in a DEPTH-entry FIFO; push_ready_o = !full; no same-cycle pop bypass when full.
REQ-021 SHALL present an accepted record on rvfi_*_o no earlier than the cycle after acceptance; outputs driven from registered FIFO head.
REQ-022 SHALL implement two states: RUN (rvfi_valid_o = !empty) and HALT (rvfi_valid_o = 0).
REQ-023 SHALL hold rvfi_insn_o/pc_rdata_o/trap_o/order_o stable while rvfi_valid_o & !rvfi_ready_i.
REQ-024 SHALL pop head and increment order counter by 1 on each transfer; 64-bit wrap to 0 after 2^64-1.
REQ-025 SHALL transition RUN->HALT on transfer of a beat with rvfi_trap_o=1; halt_o=1 from next cycle.
REQ-026 SHALL keep accepting pushes in HALT until full.
REQ-027 SHALL, on flush_i, empty FIFO and enter RUN next cycle; order counter unchanged; flush overrides same-cycle push and transfer (neither takes effect).
REQ-028 SHALL handle simultaneous push and transfer when not full: occupancy unchanged, FIFO order preserved.
REQ-029 SHALL hold outputs at don't-care-free values when empty: rvfi_insn_o/pc_rdata_o/trap_o = 0.

Reset
REQ-030 SHALL on rst_ni low, immediately: FIFO empty, state RUN, order 0, stall count 0.
REQ-031 SHALL drive during reset: push_ready_o=0, rvfi_valid_o=0, halt_o=0, all data outputs 0, stall_cnt_o=0.
REQ-032 SHALL discard in-flight records on reset mid-operation; first post-reset beat has order 0.
REQ-033 SHALL assert push_ready_o from first rising edge after rst_ni deasserts.

Configuration
REQ-034 SHALL, with RVFI_EMITTER_STALL_CNT_EN defined, count cycles with rvfi_valid_o=1 & rvfi_ready_i=0, saturating at 32'hFFFF_FFFF, cleared only by reset.
REQ-035 SHALL, without RVFI_EMITTER_STALL_CNT_EN, tie stall_cnt_o to 0 and instantiate no counter.

Verification
REQ-036 SHALL cover: push pc=0x8000_0000 insn=0x0000_0013, ready=1 -> one beat next cycle, order=0, then valid=0.
REQ-037 SHALL cover: ready=0, push 5 records with DEPTH=4 -> push_ready_o=0 after 4th; release ready -> beats in order 0..3, pcs matching push order.
REQ-038 SHALL cover: push trap record (trap=1) then normal record -> trap beat transfers, halt_o=1, valid=0; flush_i -> FIFO empty, RUN, next push emits order=1.
REQ-039 SHALL cover: rst_ni low with 3 queued records -> all outputs 0; after release push one record -> order=0.
REQ-040 SHALL cover (macro defined): valid held with ready=0 for 7 cycles -> stall_cnt_o=7; undefined -> stall_cnt_o=0.
